// File: rtl/sr_cmd_debounce.sv
// sr_cmd_debounce: debounced, mutually exclusive S/R command driver for a downstream sr_ff.
//
// Two raw request lines (set_in, clr_in) are each double-flop synchronised and debounced.
// The 0->1 edge of a debounced level is a one-cycle request. A small FSM turns each
// accepted request into a registered S or R pulse of PULSE_W cycles, followed by one
// idle GAP cycle. Requests that qualify together in IDLE are refused and flagged.
// Requests that arrive while a command is in flight are dropped.
//
// Optional feature macro: SR_VERIFY_EN. When it is defined, q_fb is checked in the GAP
// cycle, and verr pulses if the flip-flop did not take the command.
//
// Ports:
//   clk      in  rising-edge clock
//   rst      in  synchronous, active-high reset
//   set_in   in  raw set request (asynchronous, may bounce)
//   clr_in   in  raw clear request (asynchronous, may bounce)
//   q_fb     in  Q read back from sr_ff (used only with SR_VERIFY_EN)
//   S        out registered set drive
//   R        out registered reset drive
//   busy     out high in every state other than IDLE
//   conflict out one-cycle pulse when set and clear qualify on the same edge in IDLE
//   verr     out one-cycle pulse on a read-back mismatch (0 without SR_VERIFY_EN)

module sr_cmd_debounce #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned PULSE_W    = 1,
    parameter int unsigned CNT_W      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic set_in,
    input  logic clr_in,
    input  logic q_fb,
    output logic S,
    output logic R,
    output logic busy,
    output logic conflict,
    output logic verr
);

    typedef enum logic [1:0] {
        StIdle,
        StPulseS,
        StPulseR,
        StGap
    } state_e;

    localparam logic [CNT_W-1:0] DebLast   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] PulseLast = CNT_W'(PULSE_W - 1);

    // Channel index 0 is set, index 1 is clear.
    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       r_stb;
    logic [1:0]       r_req;
    logic [CNT_W-1:0] r_cnt [2];

    state_e           r_state;
    state_e           w_state_d;
    logic [CNT_W-1:0] r_pcnt;
    logic [CNT_W-1:0] w_pcnt_d;
    logic             w_conflict_d;

    logic             r_s;
    logic             r_r;
    logic             r_busy;
    logic             r_conflict;

    // ------------------------------------------------------------------
    // Synchronisers and debounce
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_stb   <= '0;
            r_req   <= '0;
            for (int i = 0; i < 2; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= {clr_in, set_in};
            r_sync2 <= r_sync1;
            for (int i = 0; i < 2; i++) begin
                r_req[i] <= 1'b0;
                if (r_sync2[i] != r_stb[i]) begin
                    // Accept the new level on the DEB_CYCLES-th consecutive differing edge.
                    if (r_cnt[i] == DebLast) begin
                        r_stb[i] <= r_sync2[i];
                        r_cnt[i] <= '0;
                        // Only a rising debounced level is a request.
                        r_req[i] <= r_sync2[i];
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Command FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_pcnt  <= '0;
        end else begin
            r_state <= w_state_d;
            r_pcnt  <= w_pcnt_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_pcnt_d     = r_pcnt;
        w_conflict_d = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_pcnt_d = '0;
                if (r_req == 2'b11) begin
                    w_conflict_d = 1'b1;
                end else if (r_req[0]) begin
                    w_state_d = StPulseS;
                end else if (r_req[1]) begin
                    w_state_d = StPulseR;
                end
            end
            StPulseS, StPulseR: begin
                if (r_pcnt == PulseLast) begin
                    w_state_d = StGap;
                    w_pcnt_d  = '0;
                end else begin
                    w_pcnt_d = r_pcnt + CNT_W'(1);
                end
            end
            StGap: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state and are
    // free of decode glitches; reset forces them low on the reset edge itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_busy     <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_s        <= (w_state_d == StPulseS);
            r_r        <= (w_state_d == StPulseR);
            r_busy     <= (w_state_d != StIdle);
            r_conflict <= w_conflict_d;
        end
    end

    assign S        = r_s;
    assign R        = r_r;
    assign busy     = r_busy;
    assign conflict = r_conflict;

    // ------------------------------------------------------------------
    // Optional read-back check
    // ------------------------------------------------------------------
`ifdef SR_VERIFY_EN
    logic r_exp;
    logic r_verr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exp  <= 1'b0;
            r_verr <= 1'b0;
        end else begin
            // Compare on the edge that leaves GAP, so verr lands in the cycle after it.
            r_verr <= (r_state == StGap) && (q_fb != r_exp);
            if (w_state_d == StPulseS) begin
                r_exp <= 1'b1;
            end else if (w_state_d == StPulseR) begin
                r_exp <= 1'b0;
            end
        end
    end

    assign verr = r_verr;
`else
    logic w_unused_q_fb;
    assign w_unused_q_fb = q_fb;
    assign verr          = 1'b0;
`endif

endmodule

// File: tb/tb_sr_cmd_debounce.sv
// Bench for sr_cmd_debounce. Two instances share the stimulus: inst0 with PULSE_W=1 and
// inst1 with PULSE_W=3 (both DEB_CYCLES=4). Each instance drives a small sr_ff model whose
// Q is fed back, with an override that forces q_fb low. Expected pulses (kind, start
// cycle, width) are queued when stimulus is issued; a negedge monitor measures every
// pulse on S, R, conflict, verr and busy and retires it against the queue.

module tb_sr_cmd_debounce;

    typedef struct {
        int kind;
        int start;
        int width;
    } ev_t;

    localparam int DebCycles = 4;

    logic clk;
    logic rst;
    logic set_in;
    logic clr_in;
    logic qforce;

    logic       s_o        [2];
    logic       r_o        [2];
    logic       busy_o     [2];
    logic       conflict_o [2];
    logic       verr_o     [2];
    logic       qm         [2];
    logic       q_fb       [2];
    logic [4:0] obs        [2];
    logic [4:0] prv        [2];
    int         st         [2][5];

    ev_t exp_q [2][$];

    int cyc = 0;
    int n_vec = 0;
    int n_fail = 0;
    int t0;

    sr_cmd_debounce #(
        .DEB_CYCLES(DebCycles),
        .PULSE_W   (1),
        .CNT_W     (8)
    ) u_dut_w1 (
        .clk     (clk),
        .rst     (rst),
        .set_in  (set_in),
        .clr_in  (clr_in),
        .q_fb    (q_fb[0]),
        .S       (s_o[0]),
        .R       (r_o[0]),
        .busy    (busy_o[0]),
        .conflict(conflict_o[0]),
        .verr    (verr_o[0])
    );

    sr_cmd_debounce #(
        .DEB_CYCLES(DebCycles),
        .PULSE_W   (3),
        .CNT_W     (8)
    ) u_dut_w3 (
        .clk     (clk),
        .rst     (rst),
        .set_in  (set_in),
        .clr_in  (clr_in),
        .q_fb    (q_fb[1]),
        .S       (s_o[1]),
        .R       (r_o[1]),
        .busy    (busy_o[1]),
        .conflict(conflict_o[1]),
        .verr    (verr_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // sr_ff model per instance (no reset, powers up at 0)
    initial begin
        qm[0] = 1'b0;
        qm[1] = 1'b0;
    end
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (s_o[i] === 1'b1) qm[i] <= 1'b1;
            else if (r_o[i] === 1'b1) qm[i] <= 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            q_fb[i] = qforce ? 1'b0 : qm[i];
            obs[i]  = {busy_o[i], verr_o[i], conflict_o[i], r_o[i], s_o[i]};
        end
    end

    function automatic string kname(input int k);
        case (k)
            0: return "S";
            1: return "R";
            2: return "conflict";
            3: return "verr";
            default: return "busy";
        endcase
    endfunction

    task automatic push_ev(input int inst, input int kind, input int start, input int width);
        ev_t e;
        e.kind  = kind;
        e.start = start;
        e.width = width;
        exp_q[inst].push_back(e);
    endtask

    // A qualified command of kind 0 (S) or 1 (R) whose input was first sampled at edge t.
    task automatic push_cmd(input int kind, input int t);
        for (int i = 0; i < 2; i++) begin
            int pw;
            pw = (i == 0) ? 1 : 3;
            push_ev(i, kind, t + DebCycles + 2, pw);
            push_ev(i, 4, t + DebCycles + 2, pw + 1);
        end
    endtask

    task automatic check_run(input int i, input int k, input int start, input int width);
        int idx;
        idx = -1;
        for (int j = 0; j < exp_q[i].size(); j++) begin
            if (idx < 0 && exp_q[i][j].kind == k) idx = j;
        end
        n_vec++;
        if (idx < 0) begin
            n_fail++;
            $display("FAIL inst%0d %s: unexpected pulse start %0d width %0d, required none",
                     i, kname(k), start, width);
        end else begin
            if (exp_q[i][idx].start != start || exp_q[i][idx].width != width) begin
                n_fail++;
                $display("FAIL inst%0d %s: got start %0d width %0d, required start %0d width %0d",
                         i, kname(k), start, width, exp_q[i][idx].start, exp_q[i][idx].width);
            end
            exp_q[i].delete(idx);
        end
    endtask

    task automatic chk(input string name, input logic got, input logic want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: measures pulse runs away from the active edge.
    initial begin
        prv[0] = '0;
        prv[1] = '0;
    end
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (obs[i][0] === 1'b1 && obs[i][1] === 1'b1) begin
                n_vec++;
                n_fail++;
                $display("FAIL inst%0d excl at cycle %0d: S=1 R=1, required not both", i, cyc);
            end
            for (int k = 0; k < 5; k++) begin
                if (obs[i][k] === 1'b1 && !prv[i][k]) begin
                    st[i][k] = cyc;
                end else if (obs[i][k] !== 1'b1 && prv[i][k]) begin
                    check_run(i, k, st[i][k], cyc - st[i][k]);
                end
                prv[i][k] = (obs[i][k] === 1'b1);
            end
        end
    end

    initial begin
        rst    = 1'b1;
        set_in = 1'b0;
        clr_in = 1'b0;
        qforce = 1'b0;
        tick(3);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_S%0d", i), s_o[i], 1'b0);
            chk($sformatf("rst_R%0d", i), r_o[i], 1'b0);
            chk($sformatf("rst_busy%0d", i), busy_o[i], 1'b0);
            chk($sformatf("rst_conflict%0d", i), conflict_o[i], 1'b0);
            chk($sformatf("rst_verr%0d", i), verr_o[i], 1'b0);
        end
        rst = 1'b0;

        // Clean set
        set_in = 1'b1;
        t0 = cyc + 1;
        push_cmd(0, t0);
        tick(14);
        set_in = 1'b0;
        tick(10);

        // Bounce: 3 high, 1 low, then held; timed from the final high run
        set_in = 1'b1;
        tick(3);
        set_in = 1'b0;
        tick(1);
        set_in = 1'b1;
        t0 = cyc + 1;
        push_cmd(0, t0);
        tick(14);
        set_in = 1'b0;
        tick(10);

        // Lone 3-cycle glitch on clear: no pulse
        clr_in = 1'b1;
        tick(3);
        clr_in = 1'b0;
        tick(10);

        // Simultaneous set and clear
        set_in = 1'b1;
        clr_in = 1'b1;
        t0 = cyc + 1;
        push_ev(0, 2, t0 + DebCycles + 2, 1);
        push_ev(1, 2, t0 + DebCycles + 2, 1);
        tick(14);
        set_in = 1'b0;
        clr_in = 1'b0;
        tick(10);

        // Clear qualifies one cycle after set, inside PULSE_S: dropped
        set_in = 1'b1;
        t0 = cyc + 1;
        push_cmd(0, t0);
        tick(1);
        clr_in = 1'b1;
        tick(14);
        set_in = 1'b0;
        clr_in = 1'b0;
        tick(10);

        // Second clear press is honoured
        clr_in = 1'b1;
        t0 = cyc + 1;
        push_cmd(1, t0);
        tick(14);
        clr_in = 1'b0;
        tick(10);

        // Reset sampled on the edge ending the second cycle of PULSE_R
        clr_in = 1'b1;
        t0 = cyc + 1;
        push_ev(0, 1, t0 + 6, 1);
        push_ev(0, 4, t0 + 6, 2);
        push_ev(1, 1, t0 + 6, 2);
        push_ev(1, 4, t0 + 6, 2);
        tick(8);
        rst = 1'b1;
        tick(1);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("midrst_R%0d", i), r_o[i], 1'b0);
            chk($sformatf("midrst_busy%0d", i), busy_o[i], 1'b0);
        end
        rst = 1'b0;
        t0 = cyc + 1;
        push_cmd(1, t0);
        tick(14);
        clr_in = 1'b0;
        tick(10);

        // Read-back forced wrong after an S pulse
        qforce = 1'b1;
        set_in = 1'b1;
        t0 = cyc + 1;
        push_cmd(0, t0);
`ifdef SR_VERIFY_EN
        push_ev(0, 3, t0 + 8, 1);
        push_ev(1, 3, t0 + 10, 1);
`endif
        tick(14);
        qforce = 1'b0;
        set_in = 1'b0;
        tick(20);

        for (int i = 0; i < 2; i++) begin
            while (exp_q[i].size() > 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL inst%0d %s: missing pulse, required start %0d width %0d",
                         i, kname(exp_q[i][0].kind), exp_q[i][0].start, exp_q[i][0].width);
                void'(exp_q[i].pop_front());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
